// File: rtl/option_feeder.sv
// Per-axis option sequencer: replays every unsolved line as an index header followed by its
// surviving options, re-enqueues the solver's put-backs and publishes the committed counts.
module option_feeder #(
  parameter int SIZE   = 11,
  parameter int OPT_W  = 16,
  parameter int CNT_W  = 7,
  parameter int DEPTH  = 1024,
  parameter int PB_LAT = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [3:0]            num_lines,
  input  logic [3:0]            index_base,
  input  logic                  load_valid,
  input  logic [OPT_W-1:0]      load_data,
  input  logic                  cnt_we,
  input  logic [3:0]            cnt_addr,
  input  logic [CNT_W-1:0]      cnt_data,
  input  logic                  start,
  output logic [OPT_W-1:0]      opt_data,
  output logic                  opt_valid,
  input  logic                  opt_ready,
  input  logic                  pb_valid,
  input  logic [OPT_W-1:0]      pb_data,
  output logic [SIZE*CNT_W-1:0] amnt,
  output logic                  round_done,
  output logic                  done,
  output logic                  stuck,
  output logic                  overflow,
  output logic [2:0]            dbg_state
);

  localparam int AW = $clog2(DEPTH);
  localparam int TW = (PB_LAT < 1) ? 1 : $clog2(PB_LAT + 1);

  typedef enum logic [2:0] {S_IDLE, S_HDR, S_OPT, S_WAIT, S_NEXT, S_FIN} state_e;

  state_e           state_q;
  logic [3:0]       line_q;
  logic             first_q;
  logic             changed_q;
  logic [CNT_W-1:0] cnt_q [SIZE];
  logic [CNT_W-1:0] rem_q;
  logic [CNT_W-1:0] acc_q;
  logic [TW-1:0]    timer_q;
  logic [AW:0]      head_q;
  logic [AW:0]      tail_q;
  logic [OPT_W-1:0] mem_q [DEPTH];
  logic [OPT_W-1:0] opt_data_q;
  logic             opt_valid_q;
  logic             round_done_q;
  logic             done_q;
  logic             stuck_q;
  logic             overflow_q;

  logic [AW-1:0]    head_idx;
  logic [AW-1:0]    head_nxt_idx;
  logic             full;
  logic             pop;
  logic             push;
  logic             push_ok;
  logic             credit;
  logic [OPT_W-1:0] push_data;
  logic [CNT_W-1:0] acc_d;
  logic             nxt_found;
  logic [3:0]       nxt_line;
  logic             all_zero;
  logic [OPT_W-1:0] hdr_word;

  // Handshake: a word transfers on a cycle where opt_valid && opt_ready; while opt_valid is
  // high and opt_ready low, opt_data holds and nothing is popped.
  assign head_idx     = head_q[AW-1:0];
  assign head_nxt_idx = head_idx + AW'(1);
  assign full         = (head_q[AW] != tail_q[AW]) && (head_idx == tail_q[AW-1:0]);
  assign pop          = (state_q == S_OPT) && opt_ready;
  assign push_ok      = push && (!full || pop);
  assign credit       = pb_valid && ((state_q == S_OPT) || (state_q == S_WAIT));
  assign acc_d        = (credit && (acc_q != '1)) ? acc_q + CNT_W'(1) : acc_q;
  assign hdr_word     = OPT_W'(index_base) + OPT_W'(nxt_line);

  always_comb begin
    push      = 1'b0;
    push_data = pb_data;
    case (state_q)
      S_IDLE: begin
        push      = load_valid;
        push_data = load_data;
      end
      S_HDR, S_OPT, S_WAIT, S_NEXT: push = pb_valid;
      default: push = 1'b0;
    endcase
  end

  // Lowest live line above the current one; first_q stands for line -1.
  always_comb begin
    nxt_found = 1'b0;
    nxt_line  = '0;
    all_zero  = 1'b1;
    for (int l = 0; l < SIZE; l++) begin
      if (4'(l) < num_lines && cnt_q[l] != '0) begin
        all_zero = 1'b0;
        if (!nxt_found && (first_q || 4'(l) > line_q)) begin
          nxt_found = 1'b1;
          nxt_line  = 4'(l);
        end
      end
    end
  end

  always_comb begin
    amnt = '0;
    for (int l = 0; l < SIZE; l++) amnt[l*CNT_W +: CNT_W] = cnt_q[l];
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem_q[tail_q[AW-1:0]] <= push_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      line_q       <= '0;
      first_q      <= 1'b0;
      changed_q    <= 1'b0;
      rem_q        <= '0;
      acc_q        <= '0;
      timer_q      <= '0;
      head_q       <= '0;
      tail_q       <= '0;
      opt_data_q   <= '0;
      opt_valid_q  <= 1'b0;
      round_done_q <= 1'b0;
      done_q       <= 1'b0;
      stuck_q      <= 1'b0;
      overflow_q   <= 1'b0;
      for (int l = 0; l < SIZE; l++) cnt_q[l] <= '0;
    end else begin
      round_done_q <= 1'b0;
      acc_q        <= acc_d;
      if (pop) head_q <= head_q + 1'b1;
      if (push_ok) tail_q <= tail_q + 1'b1;
      if (push && full && !pop) overflow_q <= 1'b1;
      case (state_q)
        S_IDLE: begin
          if (cnt_we && int'(cnt_addr) < SIZE) cnt_q[cnt_addr] <= cnt_data;
          if (start) begin
            state_q   <= S_NEXT;
            first_q   <= 1'b1;
            changed_q <= 1'b0;
          end
        end
        S_NEXT: begin
          if (nxt_found) begin
            line_q      <= nxt_line;
            first_q     <= 1'b0;
            state_q     <= S_HDR;
            opt_valid_q <= 1'b1;
            opt_data_q  <= hdr_word;
          end else begin
            round_done_q <= 1'b1;
            if (all_zero) begin
              done_q  <= 1'b1;
              state_q <= S_FIN;
            end else if (!changed_q) begin
              stuck_q <= 1'b1;
              state_q <= S_FIN;
            end else begin
              first_q   <= 1'b1;
              changed_q <= 1'b0;
            end
          end
        end
        S_HDR: begin
          if (opt_ready) begin
            state_q    <= S_OPT;
            rem_q      <= cnt_q[line_q];
            acc_q      <= '0;
            opt_data_q <= mem_q[head_idx];
          end
        end
        S_OPT: begin
          if (opt_ready) begin
            rem_q <= rem_q - CNT_W'(1);
            if (rem_q == CNT_W'(1)) begin
              state_q     <= S_WAIT;
              timer_q     <= TW'(PB_LAT);
              opt_valid_q <= 1'b0;
            end else begin
              opt_data_q <= mem_q[head_nxt_idx];
            end
          end
        end
        S_WAIT: begin
          timer_q <= timer_q - TW'(1);
          // The put-back arriving in the final WAIT cycle is still credited via acc_d.
          if (timer_q <= TW'(1)) begin
            cnt_q[line_q] <= acc_d;
            if (acc_d != cnt_q[line_q]) changed_q <= 1'b1;
            state_q <= S_NEXT;
          end
        end
        default: state_q <= S_FIN;
      endcase
    end
  end

  assign opt_data   = opt_data_q;
  assign opt_valid  = opt_valid_q;
  assign round_done = round_done_q;
  assign done       = done_q;
  assign stuck      = stuck_q;
  assign overflow   = overflow_q;
  assign dbg_state  = state_q;

endmodule

// File: tb/tb_option_feeder.sv
// Scoreboard bench for option_feeder: directed loads, hand-computed option streams and
// put-back schedules, with a monitor that checks every consumed word against exp_q.
module tb_option_feeder;
  localparam int SIZE  = 11;
  localparam int OPT_W = 16;
  localparam int CNT_W = 7;

  logic                  clk;
  logic                  rst_n;
  logic [3:0]            num_lines;
  logic [3:0]            index_base;
  logic                  load_valid;
  logic [OPT_W-1:0]      load_data;
  logic                  cnt_we;
  logic [3:0]            cnt_addr;
  logic [CNT_W-1:0]      cnt_data;
  logic                  start;
  logic [OPT_W-1:0]      opt_data;
  logic                  opt_valid;
  logic                  opt_ready;
  logic                  pb_valid;
  logic [OPT_W-1:0]      pb_data;
  logic [SIZE*CNT_W-1:0] amnt;
  logic                  round_done;
  logic                  done;
  logic                  stuck;
  logic                  overflow;
  logic [2:0]            dbg_state;

  option_feeder dut (
    .clk(clk), .rst_n(rst_n), .num_lines(num_lines), .index_base(index_base),
    .load_valid(load_valid), .load_data(load_data), .cnt_we(cnt_we), .cnt_addr(cnt_addr),
    .cnt_data(cnt_data), .start(start), .opt_data(opt_data), .opt_valid(opt_valid),
    .opt_ready(opt_ready), .pb_valid(pb_valid), .pb_data(pb_data), .amnt(amnt),
    .round_done(round_done), .done(done), .stuck(stuck), .overflow(overflow),
    .dbg_state(dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- scoreboard state ----------------
  logic [OPT_W-1:0] exp_q[$];
  typedef struct {int c; logic [OPT_W-1:0] d;} pb_t;
  pb_t pb_sched[$];
  int n_vec = 0;
  int n_err = 0;
  int start_cyc, first_hs_cyc, rd_count, rd1_cyc;
  logic [SIZE*CNT_W-1:0] rd1_amnt;
  logic prev_stall;
  logic [OPT_W-1:0] prev_data;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [SIZE*CNT_W-1:0] pack4(input int a, input int b, input int c, input int d);
    logic [SIZE*CNT_W-1:0] v;
    v = '0;
    v[0*CNT_W +: CNT_W] = CNT_W'(a);
    v[1*CNT_W +: CNT_W] = CNT_W'(b);
    v[2*CNT_W +: CNT_W] = CNT_W'(c);
    v[3*CNT_W +: CNT_W] = CNT_W'(d);
    return v;
  endfunction

  // ---------------- put-back driver (solver model) ----------------
  always @(negedge clk) begin
    pb_valid = 1'b0;
    if (pb_sched.size() > 0 && pb_sched[0].c == cyc) begin
      pb_valid = 1'b1;
      pb_data  = pb_sched.pop_front().d;
    end
  end

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    #1;
    if (rst_n) begin
      if (round_done) begin
        rd_count++;
        if (rd_count == 1) begin
          rd1_cyc  = cyc;
          rd1_amnt = amnt;
        end
      end
      if (prev_stall) begin
        check("hold_valid", opt_valid, 1);
        check("hold_data", opt_data, prev_data);
      end
      if (opt_valid && opt_ready) begin
        if (first_hs_cyc < 0) first_hs_cyc = cyc;
        if (exp_q.size() == 0) begin
          n_vec++;
          n_err++;
          $display("FAIL stream_extra: got %0h expected no word", opt_data);
        end else begin
          check("stream", opt_data, exp_q.pop_front());
        end
      end
      prev_stall = opt_valid && !opt_ready;
      prev_data  = opt_data;
    end else begin
      prev_stall = 1'b0;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    load_valid = 1'b0; cnt_we = 1'b0; start = 1'b0; opt_ready = 1'b1;
    num_lines = 4'd4; index_base = 4'd0;
    exp_q.delete();
    pb_sched.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic load_word(input logic [OPT_W-1:0] w);
    @(negedge clk);
    cnt_we = 1'b0; load_valid = 1'b1; load_data = w;
  endtask

  task automatic set_cnt(input int a, input int d);
    @(negedge clk);
    load_valid = 1'b0; cnt_we = 1'b1; cnt_addr = 4'(a); cnt_data = CNT_W'(d);
  endtask

  task automatic idle_inputs();
    @(negedge clk);
    load_valid = 1'b0; cnt_we = 1'b0;
  endtask

  task automatic do_start();
    @(negedge clk);
    load_valid = 1'b0; cnt_we = 1'b0; start = 1'b1;
    start_cyc = cyc; first_hs_cyc = -1; rd_count = 0;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic add_pb(input int off, input logic [OPT_W-1:0] d);
    pb_t e;
    e.c = start_cyc + off;
    e.d = d;
    pb_sched.push_back(e);
  endtask

  task automatic wait_end(input string name);
    int t;
    t = 0;
    while (!(done || stuck) && t < 3000) begin
      @(negedge clk);
      t++;
    end
    if (t >= 3000) begin
      n_vec++;
      n_err++;
      $display("FAIL %s_timeout: got no done/stuck expected one within 3000 cycles", name);
    end
    repeat (3) @(negedge clk);
  endtask

  task automatic setup_4x4();
    num_lines = 4'd4; index_base = 4'd0;
    load_word(16'b0011); load_word(16'b0110); load_word(16'b1100);
    load_word(16'b0011); load_word(16'b0110); load_word(16'b1100);
    load_word(16'b1010); load_word(16'b1001); load_word(16'b0101);
    load_word(16'b1101);
    set_cnt(0, 3); set_cnt(1, 3); set_cnt(2, 3); set_cnt(3, 1);
    idle_inputs();
  endtask

  task automatic push_round_4x4();
    exp_q.push_back(16'b0000); exp_q.push_back(16'b0011);
    exp_q.push_back(16'b0110); exp_q.push_back(16'b1100);
    exp_q.push_back(16'b0001); exp_q.push_back(16'b0011);
    exp_q.push_back(16'b0110); exp_q.push_back(16'b1100);
    exp_q.push_back(16'b0010); exp_q.push_back(16'b1010);
    exp_q.push_back(16'b1001); exp_q.push_back(16'b0101);
    exp_q.push_back(16'b0011); exp_q.push_back(16'b1101);
  endtask

  // ---------------- test sequence ----------------
  initial begin
    rst_n = 1'b0; prev_stall = 1'b0; pb_valid = 1'b0; pb_data = '0;
    load_valid = 1'b0; load_data = '0; cnt_we = 1'b0; cnt_addr = '0; cnt_data = '0;
    start = 1'b0; opt_ready = 1'b1; num_lines = 4'd4; index_base = 4'd0;

    // Reset state
    do_reset();
    @(negedge clk);
    check("rst_opt_valid", opt_valid, 0);
    check("rst_opt_data", opt_data, 0);
    check("rst_round_done", round_done, 0);
    check("rst_done", done, 0);
    check("rst_stuck", stuck, 0);
    check("rst_overflow", overflow, 0);
    check("rst_amnt", amnt, 0);

    // 4x4 rows, no put-backs: one round then done
    setup_4x4();
    check("t1_amnt_loaded", amnt, pack4(3, 3, 3, 1));
    push_round_4x4();
    do_start();
    wait_end("t1");
    check("t1_first_hdr_lat", first_hs_cyc - start_cyc, 2);
    check("t1_round_lat", rd1_cyc - start_cyc, 28);
    check("t1_rounds", rd_count, 1);
    check("t1_rd_amnt", rd1_amnt, 0);
    check("t1_done", done, 1);
    check("t1_stuck", stuck, 0);
    check("t1_opt_valid_fin", opt_valid, 0);
    check("t1_exp_empty", exp_q.size(), 0);

    // Put back options 2 and 3 of line 0: round 2 replays only those
    do_reset();
    setup_4x4();
    push_round_4x4();
    exp_q.push_back(16'b0000); exp_q.push_back(16'b0110); exp_q.push_back(16'b1100);
    do_start();
    add_pb(5, 16'b0110);
    add_pb(6, 16'b1100);
    wait_end("t2");
    check("t2_rounds", rd_count, 2);
    check("t2_rd1_amnt", rd1_amnt, pack4(2, 0, 0, 0));
    check("t2_done", done, 1);
    check("t2_amnt_final", amnt, 0);
    check("t2_exp_empty", exp_q.size(), 0);

    // Column instance, base 4, line 1 empty
    do_reset();
    num_lines = 4'd4; index_base = 4'd4;
    load_word(16'b1000); load_word(16'b0100); load_word(16'b0010); load_word(16'b0001);
    set_cnt(0, 2); set_cnt(1, 0); set_cnt(2, 1); set_cnt(3, 1);
    idle_inputs();
    exp_q.push_back(16'b0100); exp_q.push_back(16'b1000); exp_q.push_back(16'b0100);
    exp_q.push_back(16'b0110); exp_q.push_back(16'b0010);
    exp_q.push_back(16'b0111); exp_q.push_back(16'b0001);
    do_start();
    wait_end("t3");
    check("t3_round_lat", rd1_cyc - start_cyc, 18);
    check("t3_done", done, 1);
    check("t3_exp_empty", exp_q.size(), 0);

    // Stall opt_ready for 3 cycles mid-line
    do_reset();
    setup_4x4();
    push_round_4x4();
    do_start();
    repeat (3) @(negedge clk);
    opt_ready = 1'b0;
    repeat (3) @(negedge clk);
    opt_ready = 1'b1;
    wait_end("t4");
    check("t4_round_lat", rd1_cyc - start_cyc, 31);
    check("t4_done", done, 1);
    check("t4_exp_empty", exp_q.size(), 0);

    // Every option put back: stuck, FIN, start ignored
    do_reset();
    num_lines = 4'd2; index_base = 4'd0;
    load_word(16'b1010); load_word(16'b0101);
    set_cnt(0, 1); set_cnt(1, 1);
    idle_inputs();
    exp_q.push_back(16'b0000); exp_q.push_back(16'b1010);
    exp_q.push_back(16'b0001); exp_q.push_back(16'b0101);
    do_start();
    add_pb(4, 16'b1010);
    add_pb(9, 16'b0101);
    wait_end("t5");
    check("t5_round_lat", rd1_cyc - start_cyc, 12);
    check("t5_stuck", stuck, 1);
    check("t5_done", done, 0);
    check("t5_amnt", amnt, pack4(1, 1, 0, 0));
    do_start();
    repeat (5) @(negedge clk);
    check("t5_fin_opt_valid", opt_valid, 0);
    check("t5_rounds_after", rd_count, 0);
    check("t5_exp_empty", exp_q.size(), 0);

    // Full buffer: put-backs with pops accepted, without pop overflow, then async reset
    do_reset();
    num_lines = 4'd1; index_base = 4'd0;
    for (int i = 0; i < 1024; i++) load_word(16'h0100 + 16'(i));
    set_cnt(0, 3);
    idle_inputs();
    check("t6_full_no_ovf", overflow, 0);
    exp_q.push_back(16'h0000); exp_q.push_back(16'h0100); exp_q.push_back(16'h0101);
    do_start();
    add_pb(3, 16'hAAAA);
    add_pb(4, 16'hBBBB);
    add_pb(5, 16'hCCCC);
    repeat (4) @(negedge clk);
    check("t6_pop_push_ok", overflow, 0);
    opt_ready = 1'b0;
    @(negedge clk);
    check("t6_overflow", overflow, 1);
    check("t6_valid_before_rst", opt_valid, 1);
    check("t6_exp_empty", exp_q.size(), 0);
    rst_n = 1'b0;
    #1;
    check("t6_rst_opt_valid", opt_valid, 0);
    check("t6_rst_opt_data", opt_data, 0);
    check("t6_rst_overflow", overflow, 0);
    check("t6_rst_amnt", amnt, 0);
    check("t6_rst_done", done, 0);
    check("t6_rst_stuck", stuck, 0);
    check("t6_rst_round_done", round_done, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    opt_ready = 1'b1;
    repeat (2) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
